// File: rtl/atanh_schedule.sv
// Sequential hyperbolic-CORDIC schedule generator: emits index, atanh constant and
// repeat flag per handshake, including expanded-range negative steps and 3k+1 repeats.
module atanh_schedule #(
    parameter int FLOAT_SIZE = 24,
    parameter int INT_SIZE   = 8,
    parameter int IDX_W      = 6,
    parameter int N_NEG      = 5,
    parameter int N_POS      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  ext_mode,
    input  logic                                  abort,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic signed [IDX_W-1:0]               index,
    output logic signed [INT_SIZE+FLOAT_SIZE-1:0] value,
    output logic                                  repeat_flag,
    output logic                                  out_last
);

    localparam int VW    = INT_SIZE + FLOAT_SIZE;
    localparam int DEPTH = N_NEG + N_POS + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int NRW   = IDX_W + 2;
    localparam int PF    = 64;

    typedef enum logic {IDLE, RUN} state_t;

    // Elaboration-time fixed-point evaluation with PF fractional bits, then round to FLOAT_SIZE.
    // Positive i: atanh series in 2^-i. Non-positive i: 0.5*ln(2^(3-i) - 1) split into
    // (3-i)*ln2 plus a fast ln(1 - 2^(i-3)) series, with ln2 = 2*atanh(1/3).
    function automatic logic [VW-1:0] atanh_const(input int i);
        logic [127:0] one;
        logic [127:0] acc;
        logic [127:0] ln2;
        logic [127:0] pw;
        one = 128'd1 << PF;
        acc = '0;
        if (i >= 1) begin
            for (int n = 0; n < 64; n++) begin
                if (i * (2 * n + 1) <= PF)
                    acc = acc + ((one >> (i * (2 * n + 1))) / 128'(2 * n + 1));
            end
        end else begin
            ln2 = '0;
            pw  = one / 128'd3;
            for (int n = 0; n < 40; n++) begin
                ln2 = ln2 + pw / 128'(2 * n + 1);
                pw  = pw / 128'd9;
            end
            ln2 = ln2 << 1;
            acc = 128'(3 - i) * ln2;
            for (int n = 1; n < 64; n++) begin
                if ((3 - i) * n <= PF)
                    acc = acc - ((one >> ((3 - i) * n)) / 128'(n));
            end
            acc = acc >> 1;
        end
        acc = (acc + (one >> (FLOAT_SIZE + 1))) >> (PF - FLOAT_SIZE);
        return acc[VW-1:0];
    endfunction

    logic [VW-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic [VW-1:0] C = atanh_const(g - N_NEG);
        assign rom[g] = C;
    end

    state_t                  state_q, state_d;
    logic signed [IDX_W-1:0] index_q, index_d;
    logic signed [VW-1:0]    value_q, value_d;
    logic                    rep_q, rep_d;
    logic                    last_q, last_d;
    logic [NRW-1:0]          next_rep_q, next_rep_d;
    logic                    load;
    logic                    clear;
    logic                    cur_is_rep;
    logic                    nxt_is_rep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            value_q    <= '0;
            rep_q      <= 1'b0;
            last_q     <= 1'b0;
            next_rep_q <= NRW'(4);
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            value_q    <= value_d;
            rep_q      <= rep_d;
            last_q     <= last_d;
            next_rep_q <= next_rep_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        value_d    = value_q;
        rep_d      = rep_q;
        last_d     = last_q;
        next_rep_d = next_rep_q;
        load       = 1'b0;
        clear      = 1'b0;
        nxt_is_rep = 1'b0;
        cur_is_rep = !index_q[IDX_W-1] && ({2'b00, index_q} == next_rep_q);

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = RUN;
                    index_d    = ext_mode ? IDX_W'(-N_NEG) : IDX_W'(1);
                    rep_d      = 1'b0;
                    next_rep_d = NRW'(4);
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    clear = 1'b1;
                end else if (out_ready) begin
                    if (last_q) begin
                        clear = 1'b1;
                    end else if (cur_is_rep && !rep_q) begin
                        rep_d = 1'b1;
                        load  = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        rep_d   = 1'b0;
                        // Leaving the second pass of a repeat index: advance to the next k = 3k+1.
                        if (rep_q)
                            next_rep_d = (next_rep_q << 1) + next_rep_q + NRW'(1);
                        load = 1'b1;
                    end
                end
            end
            default: clear = 1'b1;
        endcase

        if (clear) begin
            state_d = IDLE;
            index_d = '0;
            value_d = '0;
            rep_d   = 1'b0;
            last_d  = 1'b0;
        end

        if (load) begin
            nxt_is_rep = !index_d[IDX_W-1] && ({2'b00, index_d} == next_rep_d);
            last_d     = (index_d == IDX_W'(N_POS)) && (!nxt_is_rep || rep_d);
            value_d    = '0;
            for (int g = 0; g < DEPTH; g++) begin
                if (index_d == IDX_W'(g - N_NEG))
                    value_d = rom[AW'(g)];
            end
        end
    end

    assign busy        = (state_q == RUN);
    assign out_valid   = (state_q == RUN);
    assign index       = index_q;
    assign value       = value_q;
    assign repeat_flag = rep_q;
    assign out_last    = last_q;

endmodule

// File: tb/tb_atanh_schedule.sv
// Randomized self-checking bench for atanh_schedule against a real-arithmetic
// schedule/constant model; second instance covers N_POS = 40, IDX_W = 7.
module tb_atanh_schedule;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, ext_mode = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic busy, out_valid, repeat_flag, out_last;
    logic signed [5:0]  index;
    logic signed [31:0] value;

    logic s_start = 1'b0, s_ext_mode = 1'b0, s_abort = 1'b0, s_out_ready = 1'b0;
    logic s_busy, s_out_valid, s_repeat_flag, s_out_last;
    logic signed [6:0]  s_index;
    logic signed [31:0] s_value;

    int n_cmp  = 0;
    int n_fail = 0;

    int exp_idx[$];
    bit exp_rep[$];
    bit exp_last[$];

    always #5 clk = ~clk;

    atanh_schedule dut (
        .clk(clk), .rst(rst), .start(start), .ext_mode(ext_mode), .abort(abort),
        .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .index(index),
        .value(value), .repeat_flag(repeat_flag), .out_last(out_last)
    );

    atanh_schedule #(.FLOAT_SIZE(24), .INT_SIZE(8), .IDX_W(7), .N_NEG(5), .N_POS(40)) dut_sweep (
        .clk(clk), .rst(rst), .start(s_start), .ext_mode(s_ext_mode), .abort(s_abort),
        .out_ready(s_out_ready), .busy(s_busy), .out_valid(s_out_valid), .index(s_index),
        .value(s_value), .repeat_flag(s_repeat_flag), .out_last(s_out_last)
    );

    function automatic longint model_value(int i);
        real x;
        real v;
        if (i >= 1) begin
            x = $pow(2.0, -i);
            v = 0.5 * $ln((1.0 + x) / (1.0 - x));
        end else begin
            v = 0.5 * $ln($pow(2.0, 3 - i) - 1.0);
        end
        return longint'($floor(v * $pow(2.0, 24) + 0.5));
    endfunction

    task automatic build_model(input bit ext, input int nneg, input int npos);
        int reps[$];
        int k;
        bit r;
        exp_idx.delete();
        exp_rep.delete();
        exp_last.delete();
        k = 4;
        while (k <= npos) begin
            reps.push_back(k);
            k = 3 * k + 1;
        end
        for (int i = (ext ? -nneg : 1); i <= npos; i++) begin
            exp_idx.push_back(i);
            exp_rep.push_back(1'b0);
            exp_last.push_back(1'b0);
            r = 1'b0;
            foreach (reps[j]) if (reps[j] == i) r = 1'b1;
            if (r) begin
                exp_idx.push_back(i);
                exp_rep.push_back(1'b1);
                exp_last.push_back(1'b0);
            end
        end
        exp_last[exp_last.size() - 1] = 1'b1;
    endtask

    task automatic run_schedule(input bit ext, input int stall_pct, output int n_xfer,
                                output longint v_idx0, output longint v_idx1);
        int k;
        int cyc;
        bit rdy;
        longint diff;
        logic signed [5:0]  h_idx;
        logic signed [31:0] h_val;
        logic h_rep, h_last;
        build_model(ext, 5, 16);
        v_idx0 = -1;
        v_idx1 = -1;
        start = 1'b1;
        ext_mode = ext;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ext_mode = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL latency: out_valid=%b busy=%b, expected 1 1", out_valid, busy);
        end
        k = 0;
        cyc = 0;
        while (k < exp_idx.size() && cyc < 4000) begin
            if (out_valid !== 1'b1) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL valid_drop: out_valid=%b at entry %0d, expected 1", out_valid, k);
                break;
            end
            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            h_idx = index;
            h_val = value;
            h_rep = repeat_flag;
            h_last = out_last;
            if (rdy) begin
                n_cmp++;
                if (index !== exp_idx[k] || repeat_flag !== exp_rep[k] || out_last !== exp_last[k]) begin
                    n_fail++;
                    $display("[TB] FAIL entry %0d: idx=%0d rep=%b last=%b, expected idx=%0d rep=%b last=%b",
                             k, index, repeat_flag, out_last, exp_idx[k], exp_rep[k], exp_last[k]);
                end
                n_cmp++;
                diff = longint'(value) - model_value(exp_idx[k]);
                if (diff > 1 || diff < -1) begin
                    n_fail++;
                    $display("[TB] FAIL value idx %0d: got %0d, expected %0d +/-1",
                             exp_idx[k], value, model_value(exp_idx[k]));
                end
                if (index == 0) v_idx0 = longint'(value);
                if (index == 1) v_idx1 = longint'(value);
            end
            @(negedge clk);
            cyc++;
            if (rdy) begin
                k++;
            end else begin
                n_cmp++;
                if (out_valid !== 1'b1 || index !== h_idx || value !== h_val ||
                    repeat_flag !== h_rep || out_last !== h_last) begin
                    n_fail++;
                    $display("[TB] FAIL stall_hold: idx=%0d val=%0d rep=%b last=%b, expected %0d %0d %b %b",
                             index, value, repeat_flag, out_last, h_idx, h_val, h_rep, h_last);
                end
            end
        end
        out_ready = 1'b0;
        if (cyc >= 4000) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL timeout: %0d of %0d entries transferred", k, exp_idx.size());
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_last: out_valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
        n_xfer = k;
    endtask

    task automatic test_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || index !== 6'sd0 || value !== 32'sd0 ||
            repeat_flag !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: busy=%b valid=%b idx=%0d val=%0d rep=%b last=%b, expected all 0",
                     busy, out_valid, index, value, repeat_flag, out_last);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || index !== 6'sd0 || value !== 32'sd0 ||
                repeat_flag !== 1'b0 || out_last !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_hold cycle %0d: busy=%b valid=%b idx=%0d val=%0d, expected all 0",
                         c, busy, out_valid, index, value);
            end
        end
    endtask

    task automatic test_standard();
        int n;
        longint v0, v1;
        run_schedule(1'b0, 0, n, v0, v1);
        n_cmp++;
        if (n != 18) begin
            n_fail++;
            $display("[TB] FAIL std_count: got %0d, expected 18", n);
        end
        n_cmp++;
        if (v1 < 64'h008C9F53 || v1 > 64'h008C9F55) begin
            n_fail++;
            $display("[TB] FAIL idx1_value: got %h, expected 008C9F54 +/-1", v1);
        end
    endtask

    task automatic test_extended();
        int n;
        longint v0, v1;
        run_schedule(1'b1, 0, n, v0, v1);
        n_cmp++;
        if (n != 24) begin
            n_fail++;
            $display("[TB] FAIL ext_count: got %0d, expected 24", n);
        end
        n_cmp++;
        if (v0 < 16323476 || v0 > 16323478) begin
            n_fail++;
            $display("[TB] FAIL idx0_value: got %0d, expected 16323477 +/-1", v0);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        longint v0, v1;
        run_schedule(1'b0, 0, n1, v0, v1);
        run_schedule(1'b1, 0, n2, v0, v1);
        n_cmp++;
        if (n1 != 18 || n2 != 24) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got %0d/%0d, expected 18/24", n1, n2);
        end
    endtask

    task automatic test_backpressure();
        int n1, n2;
        longint v0, v1;
        run_schedule(1'b0, 40, n1, v0, v1);
        run_schedule(1'b1, 60, n2, v0, v1);
        n_cmp++;
        if (n1 != 18 || n2 != 24) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d/%0d, expected 18/24", n1, n2);
        end
    endtask

    task automatic test_abort();
        int n;
        longint v0, v1;
        build_model(1'b0, 5, 16);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || index !== exp_idx[7]) begin
            n_fail++;
            $display("[TB] FAIL abort_entry7: valid=%b idx=%0d, expected 1 %0d", out_valid, index, exp_idx[7]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_idle: busy=%b valid=%b, expected 0 0", busy, out_valid);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_abort_idle: busy=%b valid=%b, expected 0 0", busy, out_valid);
        end
        run_schedule(1'b0, 25, n, v0, v1);
        n_cmp++;
        if (n != 18) begin
            n_fail++;
            $display("[TB] FAIL restart_count: got %0d, expected 18", n);
        end
    endtask

    task automatic test_start_ignored();
        int cnt;
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        ext_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ext_mode = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || index !== 6'sd2 || repeat_flag !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_in_run: busy=%b idx=%0d rep=%b, expected 1 2 0", busy, index, repeat_flag);
        end
        out_ready = 1'b1;
        cnt = 1;
        cyc = 0;
        while (out_valid === 1'b1 && cyc < 100) begin
            cnt++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (cnt != 18) begin
            n_fail++;
            $display("[TB] FAIL start_in_run_count: got %0d, expected 18", cnt);
        end
    endtask

    task automatic test_sweep();
        int k;
        int cyc;
        longint diff;
        build_model(1'b0, 5, 40);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_out_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (s_out_valid === 1'b1 && cyc < 200) begin
            n_cmp++;
            if (k >= exp_idx.size()) begin
                n_fail++;
                $display("[TB] FAIL sweep_extra: entry %0d idx=%0d beyond expected end", k, s_index);
            end else begin
                diff = longint'(s_value) - model_value(exp_idx[k]);
                if (s_index !== exp_idx[k] || s_repeat_flag !== exp_rep[k] ||
                    s_out_last !== exp_last[k] || diff > 1 || diff < -1) begin
                    n_fail++;
                    $display("[TB] FAIL sweep_entry %0d: idx=%0d rep=%b last=%b val=%0d, expected %0d %b %b %0d",
                             k, s_index, s_repeat_flag, s_out_last, s_value,
                             exp_idx[k], exp_rep[k], exp_last[k], model_value(exp_idx[k]));
                end
            end
            k++;
            @(negedge clk);
            cyc++;
        end
        s_out_ready = 1'b0;
        n_cmp++;
        if (k != 43) begin
            n_fail++;
            $display("[TB] FAIL sweep_count: got %0d, expected 43", k);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_standard();
        test_extended();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/atanh_schedule.md
# atanh_schedule

Sequential, parametrised successor to the combinational `atanh_LOOKUP` table. It emits, one entry per handshake, the full hyperbolic-CORDIC iteration schedule: iteration index, atanh constant, and a repeat flag. The schedule covers the optional expanded-range negative indices and the mandatory repeats at k = 4, 13, 40, …. It sits between the CORDIC controller and the hyperbolic datapath, and replaces the controller's own index counter and repeat bookkeeping.

## Interface
- FLOAT_SIZE, 24, fractional bits of `value` (Q INT_SIZE.FLOAT_SIZE, two's complement)
- INT_SIZE, 8, integer bits of `value`
- IDX_W, 6, width of signed `index`
- N_NEG, 5, number of negative/zero expanded-range steps (indices −N_NEG..0); 0 ≤ N_NEG ≤ 2^(IDX_W−1)−1
- N_POS, 16, highest positive index; 1 ≤ N_POS ≤ 2^(IDX_W−1)−1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a schedule; honoured only in IDLE
- ext_mode  in  1  sampled with `start`: 1 = include indices −N_NEG..0, 0 = start at index 1
- abort  in  1  synchronous cancel; returns to IDLE
- out_ready  in  1  consumer accepts current entry
- busy  out  1  high in RUN
- out_valid  out  1  entry present
- index  out  IDX_W  signed iteration index
- value  out  INT_SIZE+FLOAT_SIZE  signed atanh constant
- repeat_flag  out  1  entry is the second pass of a repeated index
- out_last  out  1  entry is the final one of the schedule

## Operation
- States: IDLE, RUN.
- IDLE → RUN on `start`. Latch `ext_mode`. First index = −N_NEG if ext_mode, else 1; repeat_flag = 0.
- In RUN, `out_valid` = 1. `index`, `value`, `repeat_flag` and `out_last` are stable until a cycle with `out_ready` = 1 (transfer).
- On transfer, the next entry is determined as follows:
  - If `out_last`: go to IDLE.
  - Else if index ∈ {4, 13, 40, …} (k_{j+1} = 3k_j + 1) and repeat_flag = 0: same index, repeat_flag = 1.
  - Else: index + 1, repeat_flag = 0.
- `out_last` = 1 when index = N_POS and (N_POS is not a repeat index, or repeat_flag = 1).
- Repeat indices are tracked by an internal next-repeat register (init 4, updated 3k+1 after its second pass). No fixed table.
- Value for i ≤ 0 is atanh(1 − 2^(i−2)). Value for i ≥ 1 is atanh(2^−i).
  - Each constant is rounded to nearest at FLOAT_SIZE bits.
  - Constants come from an internal ROM sized for the parameter range.
  - Entries beyond representable precision are 0.
- `abort` in RUN forces IDLE next edge; no transfer completes that cycle. `abort` in IDLE has no effect. `abort` with `start` in IDLE: abort wins, stay IDLE.
- `start` during RUN is ignored.
- Entry count: (ext_mode ? N_NEG+1 : 0) + N_POS + (number of repeat indices ≤ N_POS). Defaults: 24 (ext) / 18 (std).

## Timing
- Reset values: busy = 0, out_valid = 0, index = 0, value = 0, repeat_flag = 0, out_last = 0.
- Asserting `rst` mid-schedule takes effect immediately (async). The schedule is discarded and no partial state is retained.
- Latency: `start` sampled at edge t → out_valid = 1 with first entry after edge t (visible cycle t+1).
- Throughput: one entry per cycle with `out_ready` held high.
- After the final transfer at edge t, out_valid = 0 and busy = 0 from cycle t+1. A new `start` is accepted at edge t+1 (no dead cycle beyond that).
- All outputs are registered; no combinational path from `out_ready` to any output.

## Test plan
- Reset/idle: assert rst mid-cycle → all outputs 0 immediately. Release, no start → outputs stay 0 for 10 cycles.
- Standard schedule, out_ready = 1: start, ext_mode = 0 → 18 entries with indices 1,2,3,4,4,5..13,13,14,15,16. repeat_flag set only on the second 4 and second 13. out_last only on 16. Index 1 value = 0x008C9F54 (±1 LSB).
- Extended schedule: ext_mode = 1 → first entries −5..0 (24 total). Index 0 value within 1 LSB of round(atanh(0.75)·2^24) = 16323477.
- Backpressure: toggle out_ready randomly → sequence identical to the no-stall run; outputs never change while out_valid ∧ ¬out_ready.
- Abort/start collisions:
  - abort at entry 7 → IDLE next cycle.
  - start during RUN → ignored.
  - start + abort in IDLE → stays IDLE.
  - restart after abort → schedule begins from its first entry again.
- Parameter sweep: N_POS = 40, IDX_W = 7 → repeats at 4, 13, 40. out_last on the second 40. Entry count = 43 (std).
